btn_debounce: RTL and testbench
===============================

// Module: btn_debounce
// PURPOSE
//   Synchronises and debounces one raw Basys3 push-button input into a clean level.
//   Sits directly upstream of step_pulse_gen: btn_db drives its btn input.
//   step_pulse_gen then converts each clean press into a one-cycle step pulse
//   for the stopwatch/watch control FSMs.
//   One instance per button (run/stop, clear, mode).
// PARAMETERS
//   CLK_HZ      100_000_000  system clock frequency, Hz
//   TICK_HZ     1_000        debounce sample-tick rate, Hz; DIV = CLK_HZ/TICK_HZ, must be >= 2
//   STABLE_CNT  10           consecutive ticks of stable input needed to change btn_db (>= 1)
//   SYNC_STAGES 2            synchroniser flop count (>= 2)
// PORTS
//   clk      in   1  system clock; all logic on its rising edge
//   rst      in   1  synchronous, active-high reset
//   btn_raw  in   1  asynchronous button pin; bounces
//   btn_db   out  1  debounced, registered button level (1 = pressed)
//   busy     out  1  1 while in PRESS_WAIT or RELEASE_WAIT
// BEHAVIOUR
//   Reset (sync, rst=1 at posedge)
//   - Sync chain, tick counter, stable counter and tick -> 0.
//   - FSM -> IDLE; btn_db=0, busy=0 from the next cycle.
//   - rst overrides every other event in the same cycle.
//   Synchroniser
//   - btn_raw passes through SYNC_STAGES flops -> btn_s.
//   - The FSM sees btn_s only; latency is SYNC_STAGES cycles.
//   Tick generator
//   - Free-running counter 0..DIV-1, width $clog2(DIV).
//   - tick=1 for one cycle when the count = DIV-1; the counter wraps to 0 in that same cycle.
//   - Independent of FSM state; cleared only by rst.
//   FSM (stable counter sc, width $clog2(STABLE_CNT+1))
//   - IDLE (btn_db=0): btn_s=1 -> PRESS_WAIT, sc<=0.
//   - PRESS_WAIT:
//     - btn_s=0 in any cycle -> IDLE, sc<=0 (bounce; restart).
//     - Else on tick, sc<=sc+1.
//     - When tick and sc==STABLE_CNT-1 -> PRESSED, btn_db<=1.
//   - PRESSED (btn_db=1): btn_s=0 -> RELEASE_WAIT, sc<=0.
//   - RELEASE_WAIT:
//     - btn_s=1 in any cycle -> PRESSED, sc<=0; btn_db stays 1.
//     - Else on tick, sc<=sc+1.
//     - When tick and sc==STABLE_CNT-1 -> IDLE, btn_db<=0.
//   - Never enter any other state; an unreachable encoding -> IDLE.
//   btn_db
//   - Changes only on the wait->settled transitions above, registered on that edge.
//   - Never toggles on a glitch shorter than STABLE_CNT ticks.
//   Latency and boundaries
//   - Press-to-btn_db: SYNC_STAGES + 1 cycles + between (STABLE_CNT-1)*DIV+1 and STABLE_CNT*DIV cycles.
//   - Tick coinciding with btn_s dropping in PRESS_WAIT: the drop wins; go to IDLE.
//   - Button held through reset: after rst falls, a full PRESS_WAIT sequence runs before btn_db=1.
//     No pulse is inherited.
//   - sc saturates by construction; it never wraps.
// STRUCTURE
//   - Shared package sw_pkg: FSM state localparams (IDLE=2'd0, PRESS_WAIT=2'd1,
//     PRESSED=2'd2, RELEASE_WAIT=2'd3) and the default CLK_HZ, reused by the stopwatch tick logic.
//   - Sub-module tick_gen #(DIV): free-running divider, outputs tick; also reused by the
//     stopwatch 100 Hz base.
//   - Synchroniser, stable counter and FSM stay inline.
// TESTING (bench params CLK_HZ=100, TICK_HZ=25 -> DIV=4, STABLE_CNT=3, SYNC_STAGES=2)
//   1 Reset: rst=1 for 3 cycles with btn_raw=1 -> btn_db=0, busy=0 during reset.
//     After release, btn_db rises only after 3 ticks.
//   2 Clean press: btn_raw 0->1 held 30 cycles -> busy=1 within 3 cycles.
//     btn_db=1 within 2+1+12 cycles, stays 1.
//   3 Bounce: btn_raw toggles 1,0,1,0 every 3 cycles, then holds 1 ->
//     busy pulses, btn_db stays 0 until 3 ticks after the final rise.
//   4 Short glitch while pressed: btn_db=1, btn_raw=0 for 5 cycles ->
//     RELEASE_WAIT then back to PRESSED; btn_db never drops.
//   5 Release: btn_raw 1->0 held -> btn_db falls 3 ticks later, busy=0 afterward.
//   6 Mid-operation reset: rst=1 in PRESS_WAIT after 2 ticks -> IDLE, sc=0, btn_db=0.
//     The count restarts from 0.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared definitions for the stopwatch/watch front end: the button debouncer
// state encoding and the default system clock rate used by the tick logic.
package sw_pkg;

    // Basys3 system clock.
    localparam int unsigned DEFAULT_CLK_HZ = 100_000_000;

    // Debouncer FSM states. The two *_WAIT states are where the input is being
    // qualified; the other two are settled levels of the debounced output.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_t;

    // True while the debouncer is qualifying a change of the input level.
    function automatic logic is_wait_state(input db_state_t s);
        return (s == PRESS_WAIT) || (s == RELEASE_WAIT);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running clock divider. Emits a one-cycle tick every DIV cycles, on the
// cycle where the count sits at DIV-1; the count wraps to 0 on that same edge.
// Only reset clears it, so the tick phase is fixed relative to reset release.
module tick_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);

    // Count 0..DIV-1 and wrap; synchronous reset to 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Combinational decode of the terminal count; it reads 0 during and right
    // after reset because the count is 0 there.
    assign o_tick = w_last;

endmodule

// File: rtl/btn_debounce.sv
// Push-button synchroniser and debouncer. The raw pin is brought into the
// clock domain by a flop chain, then an FSM only lets the debounced level
// change once the synchronised input has held the new level for STABLE_CNT
// consecutive sample ticks. Any reversal during qualification restarts it.
//
// Handshake: none. btn_db is a registered level; busy is high exactly while
// a level change is being qualified. dbg_state mirrors the FSM register.
module btn_debounce
    import sw_pkg::*;
#(
    parameter int unsigned CLK_HZ      = DEFAULT_CLK_HZ,
    parameter int unsigned TICK_HZ     = 1_000,
    parameter int unsigned STABLE_CNT  = 10,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      btn_raw,
    output logic      btn_db,
    output logic      busy,
    output db_state_t dbg_state
);

    localparam int unsigned DIV     = CLK_HZ / TICK_HZ;
    localparam int unsigned SC_W    = (STABLE_CNT > 0) ? $clog2(STABLE_CNT + 1) : 1;
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(STABLE_CNT - 1);

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_btn_s;

    // Shift the asynchronous pin through the flop chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], btn_raw};
        end
    end

    assign w_btn_s = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Sample tick
    // ------------------------------------------------------------------
    logic w_tick;

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .i_clk  (clk),
        .i_rst  (rst),
        .o_tick (w_tick)
    );

    // ------------------------------------------------------------------
    // Debounce FSM and stable-tick counter
    // ------------------------------------------------------------------
    db_state_t       r_state;
    db_state_t       w_state_nxt;
    logic [SC_W-1:0] r_sc;
    logic [SC_W-1:0] w_sc_nxt;
    logic            r_btn_db;
    logic            w_db_nxt;

    // State, counter and debounced level registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_sc     <= '0;
            r_btn_db <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sc     <= w_sc_nxt;
            r_btn_db <= w_db_nxt;
        end
    end

    // Next-state logic. The counter is cleared on every state change, so it
    // only ever counts up to STABLE_CNT-1 before the state moves on and it
    // never wraps. A drop of the input takes priority over a coincident tick.
    always_comb begin
        w_state_nxt = r_state;
        w_sc_nxt    = r_sc;
        w_db_nxt    = r_btn_db;

        case (r_state)
            IDLE: begin
                if (w_btn_s) begin
                    w_state_nxt = PRESS_WAIT;
                    w_sc_nxt    = '0;
                end
            end

            PRESS_WAIT: begin
                if (!w_btn_s) begin
                    w_state_nxt = IDLE;
                    w_sc_nxt    = '0;
                end else if (w_tick) begin
                    if (r_sc == SC_LAST) begin
                        w_state_nxt = PRESSED;
                        w_sc_nxt    = '0;
                        w_db_nxt    = 1'b1;
                    end else begin
                        w_sc_nxt    = r_sc + SC_W'(1);
                    end
                end
            end

            PRESSED: begin
                if (!w_btn_s) begin
                    w_state_nxt = RELEASE_WAIT;
                    w_sc_nxt    = '0;
                end
            end

            RELEASE_WAIT: begin
                if (w_btn_s) begin
                    w_state_nxt = PRESSED;
                    w_sc_nxt    = '0;
                end else if (w_tick) begin
                    if (r_sc == SC_LAST) begin
                        w_state_nxt = IDLE;
                        w_sc_nxt    = '0;
                        w_db_nxt    = 1'b0;
                    end else begin
                        w_sc_nxt    = r_sc + SC_W'(1);
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_sc_nxt    = '0;
                w_db_nxt    = 1'b0;
            end
        endcase
    end

    assign btn_db    = r_btn_db;
    assign busy      = is_wait_state(r_state);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce with DIV=4, STABLE_CNT=3, SYNC_STAGES=2.
// The reference model tracks only levels: the synchronised input is a delay
// line of the pin, the tick is the cycle count since reset modulo DIV, and the
// debounced level flips once the input has differed from it, without a break,
// across STABLE_CNT ticks (the tick of the first differing cycle is not used).
module tb_btn_debounce;
    import sw_pkg::*;

    localparam int DIV  = 4;
    localparam int N    = 3;
    localparam int SYNC = 2;

    logic      clk = 1'b0;
    logic      rst = 1'b0;
    logic      btn_raw = 1'b0;
    logic      btn_db;
    logic      busy;
    db_state_t dbg_state;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model state.
    bit m_db   = 1'b0;
    bit m_busy = 1'b0;
    int m_ticks = 0;
    int m_cyc   = 0;
    bit m_sync_q[$];

    btn_debounce #(
        .CLK_HZ      (100),
        .TICK_HZ     (25),
        .STABLE_CNT  (N),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .btn_db    (btn_db),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        n_vec++;
        assert (obs >= lo && obs <= hi) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Advance the model by one clock edge using the inputs applied before it.
    task automatic model_edge(input bit r, input bit raw);
        bit s;
        bit tk;
        if (r) begin
            m_db    = 1'b0;
            m_busy  = 1'b0;
            m_ticks = 0;
            m_cyc   = 0;
            m_sync_q = {};
            for (int i = 0; i < SYNC; i++) m_sync_q.push_back(1'b0);
        end else begin
            s  = m_sync_q[0];
            tk = ((m_cyc % DIV) == DIV - 1);
            if (m_busy && (s != m_db)) begin
                if (tk) begin
                    if (m_ticks == N - 1) begin
                        m_db    = ~m_db;
                        m_ticks = 0;
                    end else begin
                        m_ticks++;
                    end
                end
            end else begin
                m_ticks = 0;
            end
            m_busy = (s != m_db);
            m_cyc++;
            void'(m_sync_q.pop_front());
            m_sync_q.push_back(raw);
        end
    endtask

    // Driver: apply inputs, clock once, compare both outputs 1 time unit later.
    task automatic step(input bit r, input bit raw);
        rst     = r;
        btn_raw = raw;
        @(posedge clk);
        model_edge(r, raw);
        #1;
        check_bit("btn_db", btn_db, m_db);
        check_bit("busy", busy, m_busy);
    endtask

    initial begin
        int  rise;
        int  fall;
        int  busy_at;
        bit  seen;
        bit  dropped;
        bit  lvl;
        int  len;
        bit  do_rst;

        // 1: reset held 3 cycles with the button already down
        repeat (3) step(1'b1, 1'b1);
        check_bit("rst_state_idle", (dbg_state == IDLE), 1'b1);
        rise = 0;
        for (int i = 1; i <= 30; i++) begin
            step(1'b0, 1'b1);
            if (rise == 0 && btn_db === 1'b1) rise = i;
        end
        check_range("rst_held_press_lat", rise, 12, 12);

        // 5: release after the press settles
        fall = 0;
        for (int i = 1; i <= 30; i++) begin
            step(1'b0, 1'b0);
            if (fall == 0 && btn_db === 1'b0) fall = i;
        end
        check_range("release_lat", fall, 12, 15);

        // 2: clean press from idle
        rise = 0;
        busy_at = 0;
        for (int i = 1; i <= 30; i++) begin
            step(1'b0, 1'b1);
            if (busy_at == 0 && busy === 1'b1) busy_at = i;
            if (rise == 0 && btn_db === 1'b1) rise = i;
        end
        check_range("press_busy_lat", busy_at, 3, 3);
        check_range("press_lat", rise, 12, 15);
        repeat (20) step(1'b0, 1'b0);

        // 3: bounce 1,0,1,0 in 3-cycle runs, then hold
        seen = 1'b0;
        dropped = 1'b0;
        for (int k = 0; k < 4; k++) begin
            repeat (3) begin
                step(1'b0, (k % 2 == 0));
                if (busy === 1'b1) seen = 1'b1;
                if (btn_db !== 1'b0) dropped = 1'b1;
            end
        end
        check_bit("bounce_busy_seen", seen, 1'b1);
        check_bit("bounce_db_low", dropped, 1'b0);
        rise = 0;
        for (int i = 1; i <= 25; i++) begin
            step(1'b0, 1'b1);
            if (rise == 0 && btn_db === 1'b1) rise = i;
        end
        check_range("bounce_final_lat", rise, 12, 15);

        // 4: 5-cycle glitch low while pressed
        seen = 1'b0;
        dropped = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step(1'b0, (i >= 5));
            if (busy === 1'b1) seen = 1'b1;
            if (btn_db !== 1'b1) dropped = 1'b1;
        end
        check_bit("glitch_busy_seen", seen, 1'b1);
        check_bit("glitch_db_held", dropped, 1'b0);

        // 5 again: release to idle
        repeat (20) step(1'b0, 1'b0);

        // 6: reset in PRESS_WAIT after two ticks
        repeat (11) step(1'b0, 1'b1);
        check_bit("mid_busy_before_rst", busy, 1'b1);
        step(1'b1, 1'b1);
        check_bit("mid_rst_idle", (dbg_state == IDLE), 1'b1);
        rise = 0;
        for (int i = 1; i <= 30; i++) begin
            step(1'b0, 1'b1);
            if (rise == 0 && btn_db === 1'b1) rise = i;
        end
        check_range("mid_rst_restart_lat", rise, 12, 12);

        // Random runs of random length, with occasional resets
        for (int k = 0; k < 80; k++) begin
            lvl    = 1'($urandom_range(0, 1));
            len    = $urandom_range(1, 16);
            do_rst = ($urandom_range(0, 39) == 0);
            if (do_rst) step(1'b1, lvl);
            repeat (len) step(1'b0, lvl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
